// File: rtl/adjustable_frequency_divider_bank.sv
// ---------------------------------------------------------------------------
// adjustable_frequency_divider_bank
//
// Multi-channel programmable clock divider running entirely in the clock_in
// domain. Each channel divides by its active divisor D: clock_out is high for
// ceil(D/2) cycles and then low for the rest of the period. clk_en pulses for
// one cycle on the first high cycle of every period. A new divisor is staged
// in a per-channel target register and is only adopted at a period boundary,
// so no running period is ever cut short.
//
// Ports
//   clock_in      : sole clock
//   reset         : synchronous, active-high
//   cfg_valid     : configuration request
//   cfg_ready     : request accepted when cfg_valid & cfg_ready
//   cfg_channel   : channel addressed by the request
//   cfg_divisor   : requested divisor (legal range 1..MAX_DIVISION)
//   cfg_error     : one-cycle pulse after a rejected request
//   step_divisor  : per-channel asynchronous step request (rising edge)
//   enable        : per-channel run enable
//   clock_out     : divided clock per channel
//   clk_en        : one-cycle strobe at the start of each period
//   divisor_out   : active divisor, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
// ---------------------------------------------------------------------------
module adjustable_frequency_divider_bank #(
    parameter int  CHANNELS      = 4,
    parameter int  DIV_WIDTH     = 16,
    parameter int  MAX_DIVISION  = 1024,
    parameter int  RESET_DIVISOR = 2,
    parameter int  STEP_MODE     = 0,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clock_in,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CH_W-1:0]               cfg_channel,
    input  logic [DIV_WIDTH-1:0]          cfg_divisor,
    output logic                          cfg_error,
    input  logic [CHANNELS-1:0]           step_divisor,
    input  logic [CHANNELS-1:0]           enable,
    output logic [CHANNELS-1:0]           clock_out,
    output logic [CHANNELS-1:0]           clk_en,
    output logic [CHANNELS*DIV_WIDTH-1:0] divisor_out
);

    typedef logic [DIV_WIDTH-1:0] div_t;
    // One extra bit so the +1 / doubling result can be compared against
    // MAX_DIVISION without wrapping.
    typedef logic [DIV_WIDTH:0]   ext_t;

    localparam ext_t MAX_E = ext_t'(MAX_DIVISION);
    localparam div_t RST_D = div_t'(RESET_DIVISOR);

    // High-phase length of a period: ceil(d/2).
    function automatic div_t half(input div_t d);
        return div_t'((ext_t'(d) + ext_t'(1)) >> 1);
    endfunction

    // Next target after a step request; wraps to 1 beyond MAX_DIVISION.
    function automatic div_t step_next(input div_t t);
        ext_t nv;
        if (STEP_MODE == 1) begin
            nv = {t, 1'b0};
        end else begin
            nv = ext_t'(t) + ext_t'(1);
        end
        if (nv > MAX_E) begin
            return div_t'(1);
        end
        return div_t'(nv);
    endfunction

    div_t                cnt_q [CHANNELS];
    div_t                cnt_d [CHANNELS];
    div_t                act_q [CHANNELS];
    div_t                act_d [CHANNELS];
    div_t                tgt_q [CHANNELS];
    div_t                tgt_d [CHANNELS];
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
    logic [CHANNELS-1:0] step_rise;
    logic                cfg_ready_q;
    logic                cfg_error_q;
    logic                cfg_accept;
    logic                cfg_legal;

    always_comb begin
        cfg_accept = cfg_valid && cfg_ready_q;
        cfg_legal  = cfg_accept
                     && (int'(cfg_divisor) >= 1)
                     && (int'(cfg_divisor) <= MAX_DIVISION)
                     && (int'(cfg_channel) < CHANNELS);
        step_rise  = sync2_q & ~sync3_q;
        clk_d      = '0;
        en_d       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // Target: a legal config on this channel overrides a coincident step.
            tgt_d[i] = tgt_q[i];
            if (cfg_legal && (int'(cfg_channel) == i)) begin
                tgt_d[i] = cfg_divisor;
            end else if (step_rise[i]) begin
                tgt_d[i] = step_next(tgt_q[i]);
            end

            // Counter: a disabled channel is parked on the last count of a
            // period, so its first enabled edge is a boundary.
            if (!enable[i]) begin
                cnt_d[i] = tgt_q[i] - div_t'(1);
                act_d[i] = tgt_q[i];
            end else if (cnt_q[i] == act_q[i] - div_t'(1)) begin
                cnt_d[i] = '0;
                act_d[i] = tgt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + div_t'(1);
                act_d[i] = act_q[i];
            end

            // Outputs are decoded from the next state so they line up with it.
            clk_d[i] = enable[i] && (cnt_d[i] < half(act_d[i]));
            en_d[i]  = enable[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cfg_ready_q <= 1'b0;
            cfg_error_q <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            clk_q       <= '0;
            en_q        <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= RST_D - div_t'(1);
                act_q[i] <= RST_D;
                tgt_q[i] <= RST_D;
            end
        end else begin
            cfg_ready_q <= 1'b1;
            cfg_error_q <= cfg_accept && !cfg_legal;
            // Two-flop synchroniser followed by the edge-detect history flop.
            sync1_q     <= step_divisor;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            clk_q       <= clk_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            tgt_q       <= tgt_d;
        end
    end

    always_comb begin
        divisor_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            divisor_out[i*DIV_WIDTH +: DIV_WIDTH] = act_q[i];
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_error = cfg_error_q;
    assign clock_out = clk_q;
    assign clk_en    = en_q;

endmodule

// File: tb/tb_adjustable_frequency_divider_bank.sv
// ---------------------------------------------------------------------------
// Bench for adjustable_frequency_divider_bank. Two instances share the inputs:
//   inst 0: CHANNELS=4, STEP_MODE=0 (step adds 1)
//   inst 1: CHANNELS=3, STEP_MODE=1 (step doubles; channel 3 is out of range)
// A period-level reference model predicts every output each cycle; directed
// sequences exercise the listed scenarios, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_adjustable_frequency_divider_bank;

    localparam int DW   = 16;
    localparam int MAXD = 1024;
    localparam int RD   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [1:0]    cfg_channel;
    logic [DW-1:0] cfg_divisor;
    logic [3:0]    step_divisor;
    logic [3:0]    enable;

    logic          rdy_a, err_a, rdy_b, err_b;
    logic [3:0]    co_a, ce_a;
    logic [2:0]    co_b, ce_b;
    logic [4*DW-1:0] dout_a;
    logic [3*DW-1:0] dout_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adjustable_frequency_divider_bank #(
        .CHANNELS(4), .DIV_WIDTH(DW), .MAX_DIVISION(MAXD),
        .RESET_DIVISOR(RD), .STEP_MODE(0)
    ) dut_a (
        .clock_in(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy_a),
        .cfg_channel(cfg_channel), .cfg_divisor(cfg_divisor), .cfg_error(err_a),
        .step_divisor(step_divisor), .enable(enable), .clock_out(co_a),
        .clk_en(ce_a), .divisor_out(dout_a)
    );

    adjustable_frequency_divider_bank #(
        .CHANNELS(3), .DIV_WIDTH(DW), .MAX_DIVISION(MAXD),
        .RESET_DIVISOR(RD), .STEP_MODE(1)
    ) dut_b (
        .clock_in(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy_b),
        .cfg_channel(cfg_channel), .cfg_divisor(cfg_divisor), .cfg_error(err_b),
        .step_divisor(step_divisor[2:0]), .enable(enable[2:0]), .clock_out(co_b),
        .clk_en(ce_b), .divisor_out(dout_b)
    );

    // ---------------- reference model ----------------
    // Per channel: target divisor, active divisor D and position within the
    // current period (0..D-1). Step requests are scheduled as events due two
    // edges after the edge that first sees the request high.
    int     m_tgt [2][4];
    int     m_act [2][4];
    int     m_pos [2][4];
    bit     m_clk [2][4];
    bit     m_en  [2][4];
    bit     m_prev[2][4];
    longint m_due [2][4][$];
    bit     m_rdy [2];
    bit     m_err [2];
    longint cyc = 0;

    task automatic model_edge(input int k);
        int  n;
        bit  acc, legal, step_now;
        int  old_t, nv;
        n = (k == 0) ? 4 : 3;
        if (reset) begin
            m_rdy[k] = 1'b0;
            m_err[k] = 1'b0;
            for (int c = 0; c < n; c++) begin
                m_tgt[k][c] = RD;
                m_act[k][c] = RD;
                m_pos[k][c] = RD - 1;
                m_clk[k][c] = 1'b0;
                m_en[k][c]  = 1'b0;
                m_prev[k][c] = 1'b0;
                m_due[k][c].delete();
            end
            return;
        end
        acc   = cfg_valid && m_rdy[k];
        legal = acc && (cfg_divisor >= 1) && (cfg_divisor <= MAXD) && (int'(cfg_channel) < n);
        m_err[k] = acc && !legal;
        m_rdy[k] = 1'b1;
        for (int c = 0; c < n; c++) begin
            old_t = m_tgt[k][c];
            if (!enable[c]) begin
                m_act[k][c] = old_t;
                m_pos[k][c] = old_t - 1;
                m_clk[k][c] = 1'b0;
                m_en[k][c]  = 1'b0;
            end else begin
                if (m_pos[k][c] == m_act[k][c] - 1) begin
                    m_pos[k][c] = 0;
                    m_act[k][c] = old_t;
                end else begin
                    m_pos[k][c] = m_pos[k][c] + 1;
                end
                m_clk[k][c] = m_pos[k][c] < (m_act[k][c] + 1) / 2;
                m_en[k][c]  = (m_pos[k][c] == 0);
            end
            step_now = 1'b0;
            if (m_due[k][c].size() > 0 && m_due[k][c][0] == cyc) begin
                step_now = 1'b1;
                void'(m_due[k][c].pop_front());
            end
            if (step_divisor[c] && !m_prev[k][c]) m_due[k][c].push_back(cyc + 2);
            m_prev[k][c] = step_divisor[c];
            if (legal && int'(cfg_channel) == c) begin
                m_tgt[k][c] = int'(cfg_divisor);
            end else if (step_now) begin
                nv = (k == 1) ? old_t * 2 : old_t + 1;
                m_tgt[k][c] = (nv > MAXD) ? 1 : nv;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_edge(0);
        model_edge(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic longint get_co(input int k, input int c);
        if (k == 0) return longint'(co_a[c]);
        return longint'(co_b[c]);
    endfunction

    function automatic longint get_ce(input int k, input int c);
        if (k == 0) return longint'(ce_a[c]);
        return longint'(ce_b[c]);
    endfunction

    function automatic longint get_div(input int k, input int c);
        if (k == 0) return longint'(dout_a[c*DW +: DW]);
        return longint'(dout_b[c*DW +: DW]);
    endfunction

    task automatic compare_all();
        int n;
        check("rdy0", longint'(rdy_a), longint'(m_rdy[0]));
        check("err0", longint'(err_a), longint'(m_err[0]));
        check("rdy1", longint'(rdy_b), longint'(m_rdy[1]));
        check("err1", longint'(err_b), longint'(m_err[1]));
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 4 : 3;
            for (int c = 0; c < n; c++) begin
                check($sformatf("clock_out%0d_%0d", k, c), get_co(k, c), longint'(m_clk[k][c]));
                check($sformatf("clk_en%0d_%0d", k, c), get_ce(k, c), longint'(m_en[k][c]));
                check($sformatf("divisor%0d_%0d", k, c), get_div(k, c), longint'(m_act[k][c]));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_cfg(input int ch, input int d);
        cfg_valid   = 1'b1;
        cfg_channel = 2'(ch);
        cfg_divisor = DW'(d);
        tick();
        cfg_valid   = 1'b0;
    endtask

    // Bounded wait for a period start on inst 0 channel c with divisor d.
    task automatic wait_start(input int c, input int d, input string tag);
        bit seen;
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            tick();
            if (ce_a[c] && dout_a[c*DW +: DW] == DW'(d)) seen = 1'b1;
        end
        check(tag, longint'(seen), 1);
    endtask

    task automatic pulse_step(input int c);
        step_divisor[c] = 1'b1;
        tick();
        step_divisor[c] = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_channel = '0; cfg_divisor = '0;
        step_divisor = '0; enable = '0;

        // Reset, then run all channels at the reset divisor.
        repeat (3) tick();
        check("rst_ready", longint'(rdy_a), 0);
        check("rst_clock_out", longint'(co_a), 0);
        reset = 1'b0; enable = 4'hF;
        tick();
        check("t1_clock_out_hi", longint'(co_a), 15);
        check("t1_clk_en_hi", longint'(ce_a), 15);
        check("t1_divisor", longint'(dout_a), longint'({4{16'd2}}));
        check("t1_ready", longint'(rdy_a), 1);
        tick();
        check("t1_clock_out_lo", longint'(co_a), 0);
        check("t1_clk_en_lo", longint'(ce_a), 0);
        tick();

        // Reprogram ch1 to 5 mid-period: 1,1,1,0,0 pattern afterwards.
        do_cfg(1, 5);
        wait_start(1, 5, "t2_start_seen");
        check("t2_hi0", longint'(co_a[1]), 1);
        for (int j = 1; j < 5; j++) begin
            tick();
            check($sformatf("t2_phase%0d", j), longint'(co_a[1]), (j < 3) ? 1 : 0);
            check($sformatf("t2_en%0d", j), longint'(ce_a[1]), 0);
        end
        check("t2_ch0_div", longint'(dout_a[0 +: DW]), 2);

        // Illegal requests.
        do_cfg(0, 0);
        check("t3_err_zero", longint'(err_a), 1);
        tick();
        check("t3_err_clear", longint'(err_a), 0);
        do_cfg(0, 1025);
        check("t3_err_big", longint'(err_a), 1);
        tick();
        check("t3_div_kept", longint'(dout_a[0 +: DW]), 2);
        do_cfg(3, 3);
        check("t3_err_chan_b", longint'(err_b), 1);
        check("t3_ok_chan_a", longint'(err_a), 0);
        tick();

        // Steps on ch2 (disabled so divisor_out follows the target directly).
        enable[2] = 1'b0;
        do_cfg(2, 1023);
        tick();
        check("t4_a_1023", get_div(0, 2), 1023);
        pulse_step(2);
        check("t4_a_1024", get_div(0, 2), 1024);
        pulse_step(2);
        check("t4_a_wrap", get_div(0, 2), 1);
        do_cfg(2, 512);
        tick();
        pulse_step(2);
        check("t4_b_1024", get_div(1, 2), 1024);
        pulse_step(2);
        check("t4_b_wrap", get_div(1, 2), 1);
        enable[2] = 1'b1;

        // ch0 to D=1 with a step edge detected on the same edge.
        step_divisor[0] = 1'b1;
        tick();
        step_divisor[0] = 1'b0;
        tick();
        do_cfg(0, 1);
        repeat (6) tick();
        for (int j = 0; j < 4; j++) begin
            check("t5_clock_out", longint'(co_a[0]), 1);
            check("t5_clk_en", longint'(ce_a[0]), 1);
            check("t5_div", get_div(0, 0), 1);
            tick();
        end

        // Disable ch3 mid-period at cnt=2 of D=8, then reset mid-run.
        do_cfg(3, 8);
        wait_start(3, 8, "t6_start_seen");
        repeat (2) tick();
        enable[3] = 1'b0;
        tick();
        check("t6_dis_clock_out", longint'(co_a[3]), 0);
        check("t6_dis_clk_en", longint'(ce_a[3]), 0);
        enable[3] = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("t6_rst_clock_out", longint'(co_a), 0);
        check("t6_rst_clk_en", longint'(ce_a), 0);
        check("t6_rst_div", longint'(dout_a), longint'({4{16'd2}}));
        reset = 1'b0;
        tick();

        // Randomized run against the model.
        for (int cy = 0; cy < 3000; cy++) begin
            reset     = ($urandom_range(0, 299) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_channel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       cfg_divisor = 16'd0;
                1:       cfg_divisor = 16'd1025;
                2:       cfg_divisor = 16'($urandom_range(1, 1024));
                3:       cfg_divisor = 16'd1024;
                default: cfg_divisor = 16'($urandom_range(1, 9));
            endcase
            for (int c = 0; c < 4; c++) step_divisor[c] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) enable[$urandom_range(0, 3)] ^= 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
